// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: two-requester round-robin arbiter driving the select of a
// downstream 2:1 mux. Ownership is held until the owner releases it, or until
// it has been held MAX_HOLD cycles while the other channel is waiting.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   req[1:0] request per channel (bit 0 = channel 0)
//   rel      voluntary release by the current owner
//   s        registered mux select (0 = channel 0, 1 = channel 1)
//   gnt[1:0] registered one-hot grant, 00 when idle
//   busy     registered, high whenever gnt is non-zero
//   timeout  registered one-cycle pulse on a forced handover
module mux_sel_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       rel,
  output logic       s,
  output logic [1:0] gnt,
  output logic       busy,
  output logic       timeout
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             s_q, s_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic             cur;
  logic             req_x;
  logic             req_y;
  logic             at_max;

  // State and output registers; outputs are computed from the next state so
  // they change only on a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      s_q       <= 1'b0;
      gnt_q     <= 2'b00;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      s_q       <= s_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state, hold counter and registered-output inputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    cur       = 1'b0;
    req_x     = 1'b0;
    req_y     = 1'b0;
    at_max    = 1'b0;

    case (state_q)
      IDLE: begin
        case (req)
          2'b01:   state_d = OWN0;
          2'b10:   state_d = OWN1;
          // Tie goes to the channel that did not own last.
          2'b11:   state_d = last_q ? OWN0 : OWN1;
          default: state_d = IDLE;
        endcase
      end
      OWN0, OWN1: begin
        cur    = (state_q == OWN1);
        req_x  = req[cur];
        req_y  = req[~cur];
        at_max = (cnt_q == CNT_MAX);
        if (rel || !req_x || (at_max && req_y)) begin
          last_d = cur;
          // Forced only when neither release nor request drop caused the leave.
          timeout_d = !rel && req_x;
          if (req_y) begin
            state_d = cur ? OWN0 : OWN1;
          end else begin
            state_d = IDLE;
          end
        end else if (!at_max) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Every ownership change starts the hold count from zero.
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // Output encoding derived from the next state; select holds while idle.
  always_comb begin
    gnt_d  = {state_d == OWN1, state_d == OWN0};
    busy_d = (state_d != IDLE);
    case (state_d)
      OWN0:    s_d = 1'b0;
      OWN1:    s_d = 1'b1;
      default: s_d = s_q;
    endcase
  end

  assign s       = s_q;
  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter (MAX_HOLD = 4). Stimulus tasks push
// the expected {gnt, s, busy, timeout} of each cycle into a scoreboard queue;
// each test task pops and compares after the clock edge.
module tb_mux_sel_arbiter;

  localparam int unsigned MH = 4;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic       rel;
  logic       s;
  logic [1:0] gnt;
  logic       busy;
  logic       timeout;

  int n_pass;
  int n_total;

  // Reference model state
  int m_state;  // 0 idle, 1 own0, 2 own1
  int m_cnt;
  bit m_last;
  bit m_s;

  logic [4:0] exp_q[$];

  mux_sel_arbiter #(.MAX_HOLD(MH)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .rel    (rel),
    .s      (s),
    .gnt    (gnt),
    .busy   (busy),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_state = 0;
    m_cnt   = 0;
    m_last  = 1'b1;
    m_s     = 1'b0;
  endtask

  // Advance the reference model by one edge with inputs r/rl; return outputs.
  function automatic logic [4:0] model_step(input logic [1:0] r, input logic rl);
    bit to;
    bit own1;
    bit mine;
    bit other;
    to = 1'b0;
    if (m_state == 0) begin
      if (r == 2'b01) m_state = 1;
      else if (r == 2'b10) m_state = 2;
      else if (r == 2'b11) m_state = m_last ? 1 : 2;
      m_cnt = 0;
    end else begin
      own1  = (m_state == 2);
      mine  = own1 ? r[1] : r[0];
      other = own1 ? r[0] : r[1];
      if (rl || !mine) begin
        m_last  = own1;
        m_state = other ? (own1 ? 1 : 2) : 0;
        m_cnt   = 0;
      end else if (other && m_cnt == int'(MH) - 1) begin
        m_last  = own1;
        m_state = own1 ? 1 : 2;
        m_cnt   = 0;
        to      = 1'b1;
      end else if (m_cnt < int'(MH) - 1) begin
        m_cnt = m_cnt + 1;
      end
    end
    if (m_state == 1) m_s = 1'b0;
    if (m_state == 2) m_s = 1'b1;
    return {m_state == 2, m_state == 1, m_s, m_state != 0, to};
  endfunction

  // Drive one cycle of inputs at the falling edge and queue its expectation.
  task automatic drive(input logic [1:0] r, input logic rl);
    @(negedge clk);
    req = r;
    rel = rl;
    exp_q.push_back(model_step(r, rl));
  endtask

  task automatic test_reset();
    logic [4:0] e;
    logic [4:0] a;
    @(negedge clk);
    rst = 1'b1;
    req = 2'b11;
    rel = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    a = {gnt, s, busy, timeout};
    n_total++;
    if (a !== 5'b00000)
      $display("FAIL reset_hold: got gnt=%b s=%b busy=%b to=%b, want all zero",
               gnt, s, busy, timeout);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    drive(2'b11, 1'b0);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    a = {gnt, s, busy, timeout};
    n_total++;
    if (a !== e || gnt !== 2'b01)
      $display("FAIL reset_first_grant: got %b want %b (gnt must be 01)", a, e);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [4:0] e;
    logic [4:0] a;
    logic [1:0] pat[4] = '{2'b00, 2'b10, 2'b10, 2'b00};
    for (int i = 0; i < 4; i++) begin
      drive(pat[i], 1'b0);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      a = {gnt, s, busy, timeout};
      n_total++;
      if (a !== e) $display("FAIL single step%0d: got %b want %b", i, a, e);
      else n_pass++;
    end
    // Idle after dropping channel 1: select stays at 1.
    n_total++;
    if (gnt !== 2'b00 || s !== 1'b1 || busy !== 1'b0)
      $display("FAIL single_idle_hold: got gnt=%b s=%b busy=%b, want 00 1 0", gnt, s, busy);
    else n_pass++;
  endtask

  task automatic test_contention();
    logic [4:0] e;
    logic [4:0] a;
    int tcnt;
    int bad;
    tcnt = 0;
    bad  = 0;
    for (int i = 0; i < 16; i++) begin
      drive(2'b11, 1'b0);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      a = {gnt, s, busy, timeout};
      n_total++;
      if (a !== e) $display("FAIL contention cyc%0d: got %b want %b", i, a, e);
      else n_pass++;
      if (timeout === 1'b1) tcnt++;
      if (gnt !== 2'b01 && gnt !== 2'b10) bad++;
    end
    // Switches after edges 1,5,9,13 with a grant from idle on the first.
    n_total++;
    if (tcnt !== 3) $display("FAIL contention_timeouts: got %0d want 3", tcnt);
    else n_pass++;
    n_total++;
    if (bad !== 0) $display("FAIL contention_gnt_onehot: got %0d bad cycles want 0", bad);
    else n_pass++;
    drive(2'b00, 1'b0);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    a = {gnt, s, busy, timeout};
    n_total++;
    if (a !== e) $display("FAIL contention_drain: got %b want %b", a, e);
    else n_pass++;
  endtask

  task automatic test_release();
    logic [4:0] e;
    logic [4:0] a;
    logic [1:0] pr[6] = '{2'b01, 2'b01, 2'b11, 2'b00, 2'b01, 2'b01};
    logic       pl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    // Handoff to channel 1 at cnt=1, then release with no contender and re-grant.
    for (int i = 0; i < 6; i++) begin
      drive(pr[i], pl[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      a = {gnt, s, busy, timeout};
      n_total++;
      if (a !== e) $display("FAIL release step%0d: got %b want %b", i, a, e);
      else n_pass++;
      if (i == 2) begin
        n_total++;
        if (gnt !== 2'b10 || s !== 1'b1 || timeout !== 1'b0)
          $display("FAIL release_handoff: got gnt=%b s=%b to=%b want 10 1 0", gnt, s, timeout);
        else n_pass++;
      end
    end
    drive(2'b00, 1'b0);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    a = {gnt, s, busy, timeout};
    n_total++;
    if (a !== e) $display("FAIL release_drain: got %b want %b", a, e);
    else n_pass++;
  endtask

  task automatic test_uncontested();
    logic [4:0] e;
    logic [4:0] a;
    int bad;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      drive(2'b01, 1'b0);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      a = {gnt, s, busy, timeout};
      n_total++;
      if (a !== e) $display("FAIL uncontested cyc%0d: got %b want %b", i, a, e);
      else n_pass++;
      if (gnt !== 2'b01 || timeout !== 1'b0) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL uncontested_hold: got %0d bad cycles want 0", bad);
    else n_pass++;
    // Counter saturated at MAX_HOLD-1, so a new contender forces handover at once.
    drive(2'b11, 1'b0);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    a = {gnt, s, busy, timeout};
    n_total++;
    if (a !== e || a !== 5'b10111)
      $display("FAIL uncontested_saturated: got %b want %b", a, 5'b10111);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [4:0] e;
    logic [4:0] a;
    drive(2'b10, 1'b0);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    a = {gnt, s, busy, timeout};
    n_total++;
    if (a !== e || gnt !== 2'b10) $display("FAIL async_pre: got %b want %b", a, e);
    else n_pass++;
    @(negedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    n_total++;
    if (gnt !== 2'b00 || s !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0)
      $display("FAIL async_immediate: got gnt=%b s=%b busy=%b to=%b want 00 0 0 0",
               gnt, s, busy, timeout);
    else n_pass++;
    req = 2'b11;
    rel = 1'b0;
    #1;
    rst = 1'b0;
    exp_q.push_back(model_step(2'b11, 1'b0));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    a = {gnt, s, busy, timeout};
    n_total++;
    if (a !== e || gnt !== 2'b01)
      $display("FAIL async_first_grant: got %b want %b (gnt must be 01)", a, e);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    req     = 2'b00;
    rel     = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_release();
    test_uncontested();
    test_async_reset();
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_empty: got %0d left want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
